// File: rtl/pong_pkg.sv
// pong_pkg: game state encoding, field/paddle geometry and colours shared by the Pong pipeline
package pong_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, MISS = 2'd2} game_state_t;
  localparam logic [9:0] FIELD_TOP    = 10'd34;
  localparam logic [9:0] FIELD_BOTTOM = 10'd516;
  localparam logic [9:0] FIELD_LEFT   = 10'd144;
  localparam logic [9:0] FIELD_RIGHT  = 10'd783;
  localparam logic [9:0] PADDLE_X_L   = 10'd150;
  localparam logic [9:0] PADDLE_X_R   = 10'd170;
  localparam logic [9:0] PADDLE_H     = 10'd40;
  localparam logic [9:0] PADDLE_Y0    = 10'd220;
  localparam logic [9:0] PADDLE_SPEED = 10'd4;
  localparam logic [9:0] PADDLE_MAX   = FIELD_BOTTOM - PADDLE_H + 10'd1;
  localparam logic [9:0] BALL_SIZE    = 10'd8;
  localparam logic [9:0] BALL_SPEED   = 10'd2;
  localparam logic [9:0] SERVE_X      = 10'd320;
  localparam logic [9:0] SERVE_Y      = 10'd271;
  localparam logic [9:0] V_TICK       = 10'd517;
  localparam logic [5:0] MISS_FRAMES  = 6'd60;
  localparam logic [11:0] COLOR_BG     = 12'h000;
  localparam logic [11:0] COLOR_WALL   = 12'hFFF;
  localparam logic [11:0] COLOR_PADDLE = 12'h0F0;
  localparam logic [11:0] COLOR_BALL   = 12'hF00;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous input bit
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  // shift the raw input through two flops to settle metastability
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {m, q} <= 2'b00;
    else {m, q} <= {d, m};
endmodule

// File: rtl/pong_game_engine.sv
// pong_game_engine: per-frame ball/paddle update, collision resolution and hit scoring
module pong_game_engine import pong_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_serve,
  output logic [9:0]  paddle_y,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic [15:0] score,
  output logic [1:0]  game_state,
  output logic        miss
);
  game_state_t state, state_n;
  logic up_s, down_s, serve_s, serve_d, serve_pulse;
  logic cond, cond_d, tick, hit;
  logic dx, dy, dx_n, dy_n, miss_n;
  logic [9:0] paddle_n, bx_n, by_n;
  logic [15:0] score_n;
  logic [5:0] mcnt, mcnt_n;
  sync_2ff u_up    (.clk(clk), .rst_n(rst_n), .d(btn_up),    .q(up_s));
  sync_2ff u_down  (.clk(clk), .rst_n(rst_n), .d(btn_down),  .q(down_s));
  sync_2ff u_serve (.clk(clk), .rst_n(rst_n), .d(btn_serve), .q(serve_s));
  assign cond = vCount == V_TICK && hCount == 10'd0;
  assign serve_pulse = serve_s && !serve_d;
  assign game_state = state;
  assign hit = !dx && ball_x > PADDLE_X_R && ball_x - BALL_SPEED <= PADDLE_X_R &&
               ball_y + BALL_SIZE - 10'd1 >= paddle_y && ball_y <= paddle_y + PADDLE_H - 10'd1;
  // edge-detect the blanking condition into one tick per frame, and edge-detect serve
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {cond_d, tick, serve_d} <= 3'b000;
    else {cond_d, tick, serve_d} <= {cond, cond && !cond_d, serve_s};
  // next-state: paddle every tick, ball motion/collisions in PLAY, hold-off countdown in MISS
  always_comb begin
    state_n  = state;
    paddle_n = paddle_y;
    bx_n     = ball_x;
    by_n     = ball_y;
    dx_n     = dx;
    dy_n     = dy;
    score_n  = score;
    mcnt_n   = mcnt;
    miss_n   = 1'b0;
    if (tick && up_s && !down_s)
      paddle_n = paddle_y < FIELD_TOP + PADDLE_SPEED ? FIELD_TOP : paddle_y - PADDLE_SPEED;
    else if (tick && down_s && !up_s)
      paddle_n = paddle_y > PADDLE_MAX - PADDLE_SPEED ? PADDLE_MAX : paddle_y + PADDLE_SPEED;
    case (state)
      IDLE: if (serve_pulse) begin
        state_n = PLAY;
        score_n = 16'd0;
        dx_n    = 1'b1;
        dy_n    = 1'b1;
      end
      PLAY: if (tick) begin
        if (!dy) begin
          by_n = ball_y < FIELD_TOP + BALL_SPEED ? FIELD_TOP : ball_y - BALL_SPEED;
          dy_n = ball_y < FIELD_TOP + BALL_SPEED;
        end else begin
          by_n = ball_y + BALL_SPEED + BALL_SIZE - 10'd1 > FIELD_BOTTOM ? FIELD_BOTTOM - BALL_SIZE + 10'd1 : ball_y + BALL_SPEED;
          dy_n = !(ball_y + BALL_SPEED + BALL_SIZE - 10'd1 > FIELD_BOTTOM);
        end
        if (dx) begin
          bx_n = ball_x + BALL_SPEED + BALL_SIZE - 10'd1 > FIELD_RIGHT ? FIELD_RIGHT - BALL_SIZE + 10'd1 : ball_x + BALL_SPEED;
          dx_n = !(ball_x + BALL_SPEED + BALL_SIZE - 10'd1 > FIELD_RIGHT);
        end else if (hit) begin
          bx_n    = PADDLE_X_R + 10'd1;
          dx_n    = 1'b1;
          score_n = &score ? score : score + 16'd1;
        end else if (ball_x < FIELD_LEFT + BALL_SPEED) begin
          state_n = MISS;
          miss_n  = 1'b1;
          by_n    = ball_y;
          dy_n    = dy;
        end else
          bx_n = ball_x - BALL_SPEED;
      end
      MISS: if (tick) begin
        state_n = mcnt == MISS_FRAMES - 6'd1 ? IDLE : MISS;
        mcnt_n  = mcnt == MISS_FRAMES - 6'd1 ? 6'd0 : mcnt + 6'd1;
        bx_n    = mcnt == MISS_FRAMES - 6'd1 ? SERVE_X : ball_x;
        by_n    = mcnt == MISS_FRAMES - 6'd1 ? SERVE_Y : ball_y;
      end
      default: state_n = IDLE;
    endcase
  end
  // game state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      paddle_y <= PADDLE_Y0;
      ball_x   <= SERVE_X;
      ball_y   <= SERVE_Y;
      dx       <= 1'b1;
      dy       <= 1'b1;
      score    <= 16'd0;
      mcnt     <= 6'd0;
      miss     <= 1'b0;
    end else begin
      state    <= state_n;
      paddle_y <= paddle_n;
      ball_x   <= bx_n;
      ball_y   <= by_n;
      dx       <= dx_n;
      dy       <= dy_n;
      score    <= score_n;
      mcnt     <= mcnt_n;
      miss     <= miss_n;
    end
endmodule

// File: tb/tb_pong_game_engine.sv
// tb_pong_game_engine: table vectors, directed rally/miss sequences and random frames against a frame-level model
module tb_pong_game_engine;
  logic clk = 1'b0;
  logic rst_n;
  logic [9:0] hCount, vCount;
  logic btn_up, btn_down, btn_serve;
  logic [9:0] paddle_y, ball_x, ball_y;
  logic [15:0] score;
  logic [1:0] game_state;
  logic miss;

  always #5 clk = ~clk;

  pong_game_engine dut (
    .clk(clk), .rst_n(rst_n), .hCount(hCount), .vCount(vCount),
    .btn_up(btn_up), .btn_down(btn_down), .btn_serve(btn_serve),
    .paddle_y(paddle_y), .ball_x(ball_x), .ball_y(ball_y),
    .score(score), .game_state(game_state), .miss(miss)
  );

  int n_checks = 0, n_fail = 0, miss_total = 0, frame_miss = 0;
  int m_py, m_bx, m_by, m_dx, m_dy, m_sc, m_st, m_cnt, m_miss;
  bit m_ps;

  always @(negedge clk) if (miss === 1'b1) miss_total++;

  typedef struct {
    bit up, dn, sv;
    int hold, py, bx, by, sc, st;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_py = 220; m_bx = 320; m_by = 271; m_dx = 1; m_dy = 1;
    m_sc = 0; m_st = 0; m_cnt = 0; m_ps = 0; m_miss = 0;
  endtask

  // one frame of the game: a serve edge is seen before the frame tick, then one tick of motion
  task automatic model_frame(input bit up, input bit dn, input bit sv);
    int py0, nx, ny, ndx, ndy;
    m_miss = 0;
    if (sv && !m_ps && m_st == 0) begin
      m_st = 1; m_sc = 0; m_dx = 1; m_dy = 1;
    end
    m_ps = sv;
    py0 = m_py;
    if (up && !dn) m_py = (m_py - 4 < 34) ? 34 : m_py - 4;
    else if (dn && !up) m_py = (m_py + 4 > 477) ? 477 : m_py + 4;
    if (m_st == 1) begin
      nx = m_bx; ny = m_by; ndx = m_dx; ndy = m_dy;
      if (m_dy < 0) begin
        if (m_by < 36) begin ny = 34; ndy = 1; end else ny = m_by - 2;
      end else if (m_by + 2 + 8 - 1 > 516) begin ny = 509; ndy = -1; end
      else ny = m_by + 2;
      if (m_dx > 0) begin
        if (m_bx + 2 + 8 - 1 > 783) begin nx = 776; ndx = -1; end else nx = m_bx + 2;
      end else if (m_bx > 170 && m_bx - 2 <= 170 && m_by + 7 >= py0 && m_by <= py0 + 39) begin
        nx = 171; ndx = 1;
        if (m_sc < 65535) m_sc++;
      end else if (m_bx < 146) begin
        m_st = 2; m_miss = 1; nx = m_bx; ny = m_by; ndy = m_dy;
      end else nx = m_bx - 2;
      m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy;
    end else if (m_st == 2) begin
      m_cnt++;
      if (m_cnt == 60) begin
        m_st = 0; m_cnt = 0; m_bx = 320; m_by = 271;
      end
    end
  endtask

  // drive one short synthetic frame: buttons settle, blanking row held for 'hold' clocks, then a tail
  task automatic frame(input bit up, input bit dn, input bit sv, input int hold);
    int m0;
    btn_up = up; btn_down = dn; btn_serve = sv;
    hCount = 10'd0; vCount = 10'd0;
    m0 = miss_total;
    repeat (4) @(negedge clk);
    vCount = 10'd517;
    repeat (hold) @(negedge clk);
    vCount = 10'd518;
    repeat (3) @(negedge clk);
    frame_miss = miss_total - m0;
    model_frame(up, dn, sv);
  endtask

  task automatic check_model();
    check("paddle_y", int'(paddle_y), m_py);
    check("ball_x", int'(ball_x), m_bx);
    check("ball_y", int'(ball_y), m_by);
    check("score", int'(score), m_sc);
    check("game_state", int'(game_state), m_st);
    check("miss_pulses", frame_miss, m_miss);
  endtask

  task automatic do_reset();
    btn_up = 0; btn_down = 0; btn_serve = 0;
    hCount = 10'd0; vCount = 10'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int saved, tgt;
    bit u, d, s;
    tbl[0]  = '{0, 0, 0, 4, 220, 320, 271, 0, 0};
    tbl[1]  = '{0, 0, 0, 4, 220, 320, 271, 0, 0};
    tbl[2]  = '{0, 0, 0, 4, 220, 320, 271, 0, 0};
    tbl[3]  = '{1, 0, 0, 4, 216, 320, 271, 0, 0};
    tbl[4]  = '{1, 0, 0, 4, 212, 320, 271, 0, 0};
    tbl[5]  = '{1, 1, 0, 4, 212, 320, 271, 0, 0};
    tbl[6]  = '{0, 1, 0, 4, 216, 320, 271, 0, 0};
    tbl[7]  = '{0, 0, 1, 4, 216, 322, 273, 0, 1};
    tbl[8]  = '{0, 0, 1, 4, 216, 324, 275, 0, 1};
    tbl[9]  = '{0, 0, 0, 4, 216, 326, 277, 0, 1};
    tbl[10] = '{0, 1, 0, 8, 220, 328, 279, 0, 1};

    btn_up = 0; btn_down = 0; btn_serve = 0;
    hCount = 10'd0; vCount = 10'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_paddle_y", int'(paddle_y), 220);
    check("rst_ball_x", int'(ball_x), 320);
    check("rst_ball_y", int'(ball_y), 271);
    check("rst_score", int'(score), 0);
    check("rst_state", int'(game_state), 0);
    check("rst_miss", int'(miss), 0);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      frame(tbl[i].up, tbl[i].dn, tbl[i].sv, tbl[i].hold);
      check($sformatf("tbl%0d_paddle_y", i), int'(paddle_y), tbl[i].py);
      check($sformatf("tbl%0d_ball_x", i), int'(ball_x), tbl[i].bx);
      check($sformatf("tbl%0d_ball_y", i), int'(ball_y), tbl[i].by);
      check($sformatf("tbl%0d_score", i), int'(score), tbl[i].sc);
      check($sformatf("tbl%0d_state", i), int'(game_state), tbl[i].st);
    end

    do_reset();
    for (int i = 0; i < 60; i++) begin
      frame(1, 0, 0, 4);
      check_model();
    end
    check("paddle_clamp_top", int'(paddle_y), 34);
    frame(1, 1, 0, 4);
    check("paddle_both_hold", int'(paddle_y), 34);

    do_reset();
    frame(0, 0, 1, 4);
    check_model();
    for (int i = 0; i < 1500 && m_sc == 0; i++) begin
      tgt = m_by - 16;
      frame(m_py > tgt, m_py < tgt, 0, 4);
      check_model();
    end
    check("hit_score", int'(score), 1);
    check("hit_ball_x", int'(ball_x), 171);

    for (int i = 0; i < 1500 && m_st != 2; i++) begin
      tgt = (m_by > 258) ? 34 : 477;
      frame(m_py > tgt, m_py < tgt, 0, 4);
      check_model();
    end
    check("miss_state", int'(game_state), 2);
    check("miss_pulse_once", frame_miss, 1);
    saved = m_sc;
    for (int i = 0; i < 59; i++) begin
      frame(0, 0, 0, 4);
      check_model();
    end
    check("miss_hold_59", int'(game_state), 2);
    frame(0, 0, 0, 4);
    check("miss_to_idle", int'(game_state), 0);
    check("idle_ball_x", int'(ball_x), 320);
    check("idle_ball_y", int'(ball_y), 271);
    check("idle_score_kept", int'(score), saved);
    frame(0, 0, 1, 4);
    check("reserve_score", int'(score), 0);
    check("reserve_state", int'(game_state), 1);
    for (int i = 0; i < 5; i++) begin
      frame(0, 1, 0, 4);
      check_model();
    end

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_paddle_y", int'(paddle_y), 220);
    check("midrst_ball_x", int'(ball_x), 320);
    check("midrst_ball_y", int'(ball_y), 271);
    check("midrst_score", int'(score), 0);
    check("midrst_state", int'(game_state), 0);
    do_reset();

    for (int i = 0; i < 1500; i++) begin
      u = $urandom_range(0, 1);
      d = $urandom_range(0, 1);
      s = ($urandom_range(0, 7) == 0);
      frame(u, d, s, $urandom_range(2, 6));
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
